// File: rtl/dtcm_pkg.sv
// Shared types and helpers for the data tightly-coupled memory.
// Optional DTCM_PARITY_EN adds one even-parity bit per stored byte.
package dtcm_pkg;

    typedef enum logic {INIT, RUN} fsm_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    // Even parity: the stored bit makes each byte plus its parity bit even.
    function automatic logic [WORD_BYTES-1:0] byte_parity(input logic [WORD_W-1:0] w);
        logic [WORD_BYTES-1:0] p;
        for (int b = 0; b < WORD_BYTES; b++) begin
            p[b] = ^w[b*BYTE_W +: BYTE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/dtcm_ram_if.sv
// Core DTCM port plus the loader/debug host port, as seen between requester and responder.
// master = requester side (core + host), slave = the RAM.
interface dtcm_ram_if;
    import dtcm_pkg::*;

    logic                  dtcm_en;
    logic [WORD_BYTES-1:0] dtcm_wen;
    logic [31:0]           dtcm_addr;
    logic [WORD_W-1:0]     dtcm_wdata;
    logic [WORD_W-1:0]     dtcm_rdata;
    logic                  dtcm_busy;
    logic                  dtcm_perr;

    logic                  host_req;
    logic                  host_we;
    logic [WORD_BYTES-1:0] host_be;
    logic [31:0]           host_addr;
    logic [WORD_W-1:0]     host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [WORD_W-1:0]     host_rdata;
    logic                  host_perr;

    modport master (
        output dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata,
        input  dtcm_rdata, dtcm_busy, dtcm_perr,
        output host_req, host_we, host_be, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_perr
    );

    modport slave (
        input  dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata,
        output dtcm_rdata, dtcm_busy, dtcm_perr,
        input  host_req, host_we, host_be, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_perr
    );
endinterface

// File: rtl/dtcm_array.sv
// Plain single-port synchronous RAM, per-byte write enables, registered read data.
// Kept free of policy so it can be swapped for a foundry macro.
module dtcm_array
    import dtcm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [WORD_BYTES-1:0] we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] bit_we;

    // Data bits follow their byte lane; bits above the word are per-lane parity.
    always_comb begin
        bit_we = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < WORD_W) bit_we[i] = we_i[(i / BYTE_W) % WORD_BYTES];
            else            bit_we[i] = we_i[i % WORD_BYTES];
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (bit_we[i]) mem_q[addr_i][i] <= wdata_i[i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dtcm_ram.sv
// DTCM responder: zero-fill after reset, core-priority arbitration, per-port read hold.
// Optional DTCM_PARITY_EN stores and checks even parity per byte.
module dtcm_ram
    import dtcm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic       clk,
    input  logic       reset,
    dtcm_ram_if.slave  bus
);

`ifdef DTCM_PARITY_EN
    localparam int MEM_W = WORD_W + WORD_BYTES;
`else
    localparam int MEM_W = WORD_W;
`endif

    fsm_e                  fsm_q;
    logic [DEPTH_LOG2-1:0] cnt_q;
    logic                  busy_q;
    logic                  run;

    logic                  gnt;
    logic                  core_rd;
    logic                  host_rd;

    logic                  arr_en;
    logic [WORD_BYTES-1:0] arr_we;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic [WORD_W-1:0]     arr_wword;
    logic [MEM_W-1:0]      arr_wdata;
    logic [MEM_W-1:0]      arr_rdata;

    logic                  core_rd_q, host_rd_q;
    logic [WORD_W-1:0]     dtcm_hold_q, host_hold_q;
    logic [WORD_W-1:0]     dtcm_rdata_d, host_rdata_d;

    assign run     = (fsm_q == RUN);
    assign gnt     = bus.host_req & ~bus.dtcm_en & run;
    assign core_rd = run & bus.dtcm_en & (bus.dtcm_wen == '0);
    assign host_rd = gnt & ~bus.host_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= INIT;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else begin
            case (fsm_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        fsm_q  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single array port: zero-fill, else core, else a granted host access.
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = '0;
        arr_addr  = cnt_q;
        arr_wword = '0;
        if (!run) begin
            arr_en = ~reset;
            arr_we = reset ? '0 : '1;
        end else if (bus.dtcm_en) begin
            arr_en    = 1'b1;
            arr_we    = bus.dtcm_wen;
            arr_addr  = bus.dtcm_addr[DEPTH_LOG2+1:2];
            arr_wword = bus.dtcm_wdata;
        end else if (gnt) begin
            arr_en    = 1'b1;
            arr_we    = bus.host_we ? bus.host_be : '0;
            arr_addr  = bus.host_addr[DEPTH_LOG2+1:2];
            arr_wword = bus.host_wdata;
        end
    end

`ifdef DTCM_PARITY_EN
    assign arr_wdata = {byte_parity(arr_wword), arr_wword};
`else
    assign arr_wdata = arr_wword;
`endif

    dtcm_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (MEM_W)
    ) u_arr (
        .clk     (clk),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // The array output is shared, so each port keeps its own copy of its last read.
    assign dtcm_rdata_d = core_rd_q ? arr_rdata[WORD_W-1:0] : dtcm_hold_q;
    assign host_rdata_d = host_rd_q ? arr_rdata[WORD_W-1:0] : host_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rd_q   <= 1'b0;
            host_rd_q   <= 1'b0;
            dtcm_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            core_rd_q   <= core_rd;
            host_rd_q   <= host_rd;
            dtcm_hold_q <= dtcm_rdata_d;
            host_hold_q <= host_rdata_d;
        end
    end

    assign bus.dtcm_rdata  = dtcm_rdata_d;
    assign bus.dtcm_busy   = busy_q;
    assign bus.host_gnt    = gnt;
    assign bus.host_rvalid = host_rd_q;
    assign bus.host_rdata  = host_rdata_d;

`ifdef DTCM_PARITY_EN
    logic rd_perr, dtcm_perr_q, host_perr_q;
    logic dtcm_perr_d, host_perr_d;

    assign rd_perr     = |(byte_parity(arr_rdata[WORD_W-1:0]) ^ arr_rdata[MEM_W-1:WORD_W]);
    assign dtcm_perr_d = core_rd_q ? rd_perr : dtcm_perr_q;
    assign host_perr_d = host_rd_q ? rd_perr : host_perr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dtcm_perr_q <= 1'b0;
            host_perr_q <= 1'b0;
        end else begin
            dtcm_perr_q <= dtcm_perr_d;
            host_perr_q <= host_perr_d;
        end
    end

    assign bus.dtcm_perr = dtcm_perr_d;
    assign bus.host_perr = host_perr_d;
`else
    assign bus.dtcm_perr = 1'b0;
    assign bus.host_perr = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{bus.dtcm_addr[31:DEPTH_LOG2+2], bus.dtcm_addr[1:0],
                           bus.host_addr[31:DEPTH_LOG2+2], bus.host_addr[1:0]};

endmodule

// File: tb/tb_dtcm_ram.sv
// Bench for dtcm_ram at DEPTH_LOG2=4: directed scenarios plus random traffic,
// all outputs compared every cycle against an array-based model of the memory.
module tb_dtcm_ram;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    always #5 clk = ~clk;

    dtcm_ram_if bus();

    dtcm_ram #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [16];
    bit          mflip[16];
    int          init_idx = 0;
    bit          mrun     = 1'b0;
    logic        exp_busy = 1'b1, exp_rvalid = 1'b0, exp_perr = 1'b0, exp_hperr = 1'b0;
    logic [31:0] exp_rdata = '0, exp_hrdata = '0;

    task automatic mwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int w;
        w = widx(a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mmem[w][b*8 +: 8] = d[b*8 +: 8];
                if (b == 0) mflip[w] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        logic eg;
        if (!done) begin
            eg = bus.host_req & ~bus.dtcm_en & mrun;
            chk("busy",   {31'b0, bus.dtcm_busy},   {31'b0, exp_busy});
            chk("gnt",    {31'b0, bus.host_gnt},    {31'b0, eg});
            chk("rvalid", {31'b0, bus.host_rvalid}, {31'b0, exp_rvalid});
            chk("rdata",  bus.dtcm_rdata, exp_rdata);
            chk("hrdata", bus.host_rdata, exp_hrdata);
            chk("perr",   {31'b0, bus.dtcm_perr},   {31'b0, exp_perr});
            chk("hperr",  {31'b0, bus.host_perr},   {31'b0, exp_hperr});

            // effect of the coming rising edge
            if (reset) begin
                mrun = 0; init_idx = 0; exp_busy = 1;
                exp_rdata = '0; exp_hrdata = '0; exp_rvalid = 0; exp_perr = 0; exp_hperr = 0;
            end else if (!mrun) begin
                mmem[init_idx] = '0;
                mflip[init_idx] = 1'b0;
                init_idx++;
                exp_rvalid = 0;
                if (init_idx == 16) begin
                    mrun = 1; exp_busy = 0;
                end
            end else begin
                exp_rvalid = 0;
                if (bus.dtcm_en) begin
                    if (bus.dtcm_wen != 4'h0) mwrite(bus.dtcm_addr, bus.dtcm_wen, bus.dtcm_wdata);
                    else begin
                        exp_rdata = mmem[widx(bus.dtcm_addr)];
                        exp_perr  = mflip[widx(bus.dtcm_addr)];
                    end
                end else if (bus.host_req) begin
                    if (bus.host_we) mwrite(bus.host_addr, bus.host_be, bus.host_wdata);
                    else begin
                        exp_rvalid = 1;
                        exp_hrdata = mmem[widx(bus.host_addr)];
                        exp_hperr  = mflip[widx(bus.host_addr)];
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.dtcm_en = 0; bus.dtcm_wen = '0; bus.dtcm_addr = '0; bus.dtcm_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_be = '0; bus.host_addr = '0; bus.host_wdata = '0;
    endtask

    task automatic core(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
        bus.dtcm_en = 1; bus.dtcm_wen = wen; bus.dtcm_addr = a; bus.dtcm_wdata = d;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (bus.dtcm_busy && n < 100) begin
            #1;
            chk({name, "_gnt_init"}, {31'b0, bus.host_gnt}, 32'd0);
            tick();
            n++;
        end
        bus.host_req = 0;
        chk({name, "_busy_cycles"}, n, 32'd16);
    endtask

    task automatic read_all_zero(input string name);
        for (int w = 0; w < 16; w++) begin
            core(4'h0, w * 4 + 32'h1000, '0);
            tick();
            chk(name, bus.dtcm_rdata, 32'h0);
        end
        idle();
    endtask

    initial begin
        logic [31:0] r;
        bit          hpend, g;
        int          n;

        reset = 1;
        idle();
        tick(); tick();
        chk("rst_rdata",  bus.dtcm_rdata, 32'h0);
        chk("rst_busy",   {31'b0, bus.dtcm_busy}, 32'd1);
        reset = 0;
        bus.host_req = 1;

        // 1: zero-fill duration, host locked out, memory zero
        wait_init("t1");
        read_all_zero("t1_zero");

        // 2: byte-lane writes
        core(4'hf, 32'h8, 32'h11223344);      tick();
        core(4'h1, 32'h8, 32'hA5A5A5A5);      tick();
        core(4'h0, 32'h8, '0);                tick();
        chk("t2_lane0", bus.dtcm_rdata, 32'h112233A5);
        core(4'hc, 32'h8, 32'hBEEFBEEF);      tick();
        chk("t2_hold_after_wr", bus.dtcm_rdata, 32'h112233A5);
        core(4'h0, 32'h8, '0);                tick();
        chk("t2_lane32", bus.dtcm_rdata, 32'hBEEF33A5);

        // 3: host read starved by core, then granted on first idle cycle
        core(4'hf, 32'h20, 32'h0BADF00D);     tick();
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 32'h20;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            core(4'hf, 32'h30 + i * 4, 32'h1234_0000 + i);
            #1;
            if (bus.host_gnt) n++;
            tick();
        end
        chk("t3_gnt_while_core", n, 32'd0);
        bus.dtcm_en = 0;
        #1;
        chk("t3_gnt_idle", {31'b0, bus.host_gnt}, 32'd1);
        tick();
        bus.host_req = 0;
        chk("t3_rvalid", {31'b0, bus.host_rvalid}, 32'd1);
        chk("t3_hrdata", bus.host_rdata, 32'h0BADF00D);
        chk("t3_core_kept", bus.dtcm_rdata, 32'hBEEF33A5);
        tick();
        chk("t3_rvalid_pulse", {31'b0, bus.host_rvalid}, 32'd0);

        // 4: host write then immediate core read
        bus.host_req = 1; bus.host_we = 1; bus.host_be = 4'hf;
        bus.host_addr = 32'h40; bus.host_wdata = 32'hDEADBEEF;
        tick();
        idle();
        core(4'h0, 32'h40, '0);               tick();
        chk("t4_host_wr", bus.dtcm_rdata, 32'hDEADBEEF);
        idle();

`ifdef DTCM_PARITY_EN
        // 6: injected parity error on word 3
        dut.u_arr.mem_q[3][32] = ~dut.u_arr.mem_q[3][32];
        mflip[3] = 1'b1;
        core(4'h0, 32'hC, '0);                tick();
        chk("t6_perr_bad", {31'b0, bus.dtcm_perr}, 32'd1);
        core(4'h0, 32'h10, '0);               tick();
        chk("t6_perr_clean", {31'b0, bus.dtcm_perr}, 32'd0);
        idle();
`else
        core(4'h0, 32'hC, '0);                tick();
        chk("t6_perr_off", {31'b0, bus.dtcm_perr}, 32'd0);
        idle();
`endif

        // random traffic; host request held until granted
        hpend = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            if (r[0]) begin
                bus.dtcm_en = 1;
                bus.dtcm_wen = r[1] ? 4'h0 : r[5:2];
                bus.dtcm_addr = $urandom();
                bus.dtcm_wdata = $urandom();
            end else begin
                bus.dtcm_en = 0;
            end
            if (!hpend && r[7:6] != 2'b00) begin
                hpend = 1;
                bus.host_we = r[8];
                bus.host_be = r[12:9];
                bus.host_addr = $urandom();
                bus.host_wdata = $urandom();
            end
            bus.host_req = hpend;
            #1;
            g = bus.host_gnt;
            tick();
            if (g) hpend = 0;
        end
        idle();
        tick();

        // 5: reset in the middle of zero-fill restarts it
        reset = 1; tick();
        chk("t5_rst_hrdata", bus.host_rdata, 32'h0);
        chk("t5_rst_rvalid", {31'b0, bus.host_rvalid}, 32'd0);
        reset = 0;
        repeat (7) tick();
        chk("t5_busy_mid", {31'b0, bus.dtcm_busy}, 32'd1);
        reset = 1; tick();
        reset = 0;
        wait_init("t5");
        read_all_zero("t5_zero");
        tick();

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
